csr_gpr_regfile: RTL and testbench
==================================

// Module: csr_gpr_regfile
// PURPOSE
//   Core architectural state: 32x32 integer register file (x0 hard-wired 0) plus RV32 machine-mode CSR file.
//   One write port and two combinational read ports for GPRs; one write port and one combinational read port for CSRs.
//   Sits between decode (read addresses), writeback (rd data from load unit and scoreboard/ALU) and CSR instruction execution.
// PARAMETERS
//   DATA_W      32  register/CSR data width
//   REG_ADDR_W  5   GPR address width (32 entries)
//   CSR_ADDR_W  12  CSR address width
// PORTS
//   clk            in   1           rising-edge clock
//   rst            in   1           asynchronous, active-low reset
//   csr_waddr      in   CSR_ADDR_W  CSR write address; 12'h000 (mdisable) = no write
//   csr_wdata      in   DATA_W      CSR write data
//   csr_raddr      in   CSR_ADDR_W  CSR read address
//   rd_waddr       in   REG_ADDR_W  GPR write address; 0 = no write
//   extl_rd_wdata  in   DATA_W      rd data from load/external path (0 when idle)
//   sb_rd_wdata    in   DATA_W      rd data from scoreboard/execute path (0 when idle)
//   rs1_raddr      in   REG_ADDR_W  GPR read address 1
//   rs2_raddr      in   REG_ADDR_W  GPR read address 2
//   csr_rdata_o    out  DATA_W      CSR read data (combinational)
//   rs1_rdata_o    out  DATA_W      GPR read data 1 (combinational)
//   rs2_rdata_o    out  DATA_W      GPR read data 2 (combinational)
// BEHAVIOUR
//   - Reset (rst=0, async): all GPRs and writable CSRs cleared to 0 immediately; outputs follow combinationally.
//   - GPR write: on posedge, if rd_waddr!=0, x[rd_waddr] <= extl_rd_wdata | sb_rd_wdata (sources are mutually exclusive).
//   - rd_waddr==0: no write; x0 always reads 0.
//   - GPR read: rsN_rdata_o = 0 if rsN_raddr==0; else if rsN_raddr==rd_waddr, forwards the write data this cycle; else x[rsN_raddr].
//   - CSR map (RW unless noted): mstatus 0x300, misa 0x301 (RO 32'h4000_0100), mie 0x304, mtvec 0x305,
//     mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, mcycleh 0xB80,
//     mvendorid 0xF11 / marchid 0xF12 / mimpid 0xF13 / mhartid 0xF14 (RO, all 0).
//   - RW CSRs are full 32-bit writable; writes to RO or unmapped addresses (incl. 0x000) are ignored.
//   - CSR write: on posedge, csr[csr_waddr] <= csr_wdata.
//   - CSR read: unmapped -> 0. If csr_raddr==csr_waddr and the target is writable, csr_wdata is forwarded the same cycle.
//   - Latency: reads 0 cycles; writes visible in storage the cycle after the edge (visible the same cycle via bypass).
// CONFIGURATION
//   CSR_MCYCLE_EN defined: {mcycleh,mcycle} is a 64-bit counter.
//     - +1 every clk after reset release; carry from mcycle 0xFFFF_FFFF into mcycleh.
//     - A CSR write to either half wins over the increment in that cycle (other half still increments/carries normally).
//   CSR_MCYCLE_EN undefined: mcycle/mcycleh read 0, writes ignored, no counter logic.
// STRUCTURE
//   Shared package/defines: DATA_W, REG_ADDR_W, CSR_ADDR_W, ZERO_REG=5'd0, RST polarity, all CSR address constants
//   (incl. mdisable=12'h000) and MISA value.
//   One natural sub-module: gpr_bank (32x32 array, 1W/2R, x0 and bypass logic); CSR decode/storage stays in top.
// TESTING
//   1. Reset: rst=0 -> rs1/rs2/csr_rdata_o = 0 (csr_raddr=mepc), storage cleared.
//   2. rd_waddr=0, extl=0xFFFF, sb=0xFFFF0000 -> x0 still reads 0.
//      rd_waddr=1, extl=0x8 -> x1 reads 0x8. rd_waddr=2, sb=0x2 -> x2 reads 0x2.
//   3. Bypass: rs1_raddr=4, rd_waddr=4, extl=0x4 in same cycle -> rs1_rdata_o=0x4 before edge; x4=0x4 after.
//   4. CSR: write mepc=0xC3 -> read mepc = 0xC3.
//      Write to mdisable (0x000) -> no CSR changes.
//      Read mvendorid -> 0; read misa -> 0x40000100.
//   5. CSR bypass: csr_raddr=csr_waddr=mstatus, wdata=0xAA -> csr_rdata_o=0xAA same cycle, persists after.
//   6. CSR_MCYCLE_EN:
//      - mcycle increases by 1 per clk.
//      - Write mcycle=0xFFFF_FFFF -> next cycle mcycle=0, mcycleh+1.
//      - Without the macro, mcycle reads 0.

Source files
------------

// File: rtl/csr_gpr_regfile_pkg.sv
// Shared constants and types for the GPR/CSR architectural state block.
// Optional feature macro: CSR_MCYCLE_EN (64-bit mcycle/mcycleh counter).
package csr_gpr_regfile_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CSR_ADDR_W = 12;
  localparam int NUM_GPRS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG   = 5'd0;
  // Level of rst that holds the block in reset.
  localparam logic                  RST_ACTIVE = 1'b0;

  localparam logic [DATA_W-1:0] MISA_VALUE = 32'h4000_0100;

  typedef enum logic [CSR_ADDR_W-1:0] {
    CSR_MDISABLE  = 12'h000,
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MVENDORID = 12'hF11,
    CSR_MARCHID   = 12'hF12,
    CSR_MIMPID    = 12'hF13,
    CSR_MHARTID   = 12'hF14
  } csr_addr_e;

  // Plain read/write machine-mode CSRs kept as one register bundle.
  typedef struct packed {
    logic [DATA_W-1:0] mstatus;
    logic [DATA_W-1:0] mie;
    logic [DATA_W-1:0] mtvec;
    logic [DATA_W-1:0] mscratch;
    logic [DATA_W-1:0] mepc;
    logic [DATA_W-1:0] mcause;
    logic [DATA_W-1:0] mtval;
    logic [DATA_W-1:0] mip;
  } csr_rw_t;

  // True for addresses that accept writes; also gates same-cycle CSR bypass.
  function automatic logic csr_is_writable(input logic [CSR_ADDR_W-1:0] addr);
    logic wr;
    wr = 1'b0;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP: wr = 1'b1;
`ifdef CSR_MCYCLE_EN
      CSR_MCYCLE, CSR_MCYCLEH:                  wr = 1'b1;
`endif
      default:                                  wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/csr_gpr_regfile_if.sv
// Bundle of decode/writeback/CSR-execute signals around the register file.
// master: the pipeline side driving addresses and write data.
// slave:  the register file returning combinational read data.
interface csr_gpr_regfile_if #(
  parameter int DATA_W     = csr_gpr_regfile_pkg::DATA_W,
  parameter int REG_ADDR_W = csr_gpr_regfile_pkg::REG_ADDR_W,
  parameter int CSR_ADDR_W = csr_gpr_regfile_pkg::CSR_ADDR_W
);
  logic [CSR_ADDR_W-1:0] csr_waddr;
  logic [DATA_W-1:0]     csr_wdata;
  logic [CSR_ADDR_W-1:0] csr_raddr;
  logic [REG_ADDR_W-1:0] rd_waddr;
  logic [DATA_W-1:0]     extl_rd_wdata;
  logic [DATA_W-1:0]     sb_rd_wdata;
  logic [REG_ADDR_W-1:0] rs1_raddr;
  logic [REG_ADDR_W-1:0] rs2_raddr;
  logic [DATA_W-1:0]     csr_rdata_o;
  logic [DATA_W-1:0]     rs1_rdata_o;
  logic [DATA_W-1:0]     rs2_rdata_o;

  modport master (
    output csr_waddr, csr_wdata, csr_raddr,
    output rd_waddr, extl_rd_wdata, sb_rd_wdata,
    output rs1_raddr, rs2_raddr,
    input  csr_rdata_o, rs1_rdata_o, rs2_rdata_o
  );

  modport slave (
    input  csr_waddr, csr_wdata, csr_raddr,
    input  rd_waddr, extl_rd_wdata, sb_rd_wdata,
    input  rs1_raddr, rs2_raddr,
    output csr_rdata_o, rs1_rdata_o, rs2_rdata_o
  );
endinterface

// File: rtl/csr_gpr_regfile_gpr_bank.sv
// 32-entry integer register bank: one write port, two combinational read
// ports, x0 hard-wired to zero, write-to-read bypass within the same cycle.
module csr_gpr_regfile_gpr_bank #(
  parameter int DATA_W     = csr_gpr_regfile_pkg::DATA_W,
  parameter int REG_ADDR_W = csr_gpr_regfile_pkg::REG_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REG_ADDR_W-1:0]      rd_waddr,
  input  logic [DATA_W-1:0]          rd_wdata,
  input  logic [1:0][REG_ADDR_W-1:0] rs_raddr,
  output logic [1:0][DATA_W-1:0]     rs_rdata
);
  import csr_gpr_regfile_pkg::*;

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  // Entry 0 has no storage; reads of x0 are forced to zero below.
  logic [DATA_W-1:0] regs_reg [1:NUM_REGS-1];

  genvar gi;

  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_row
      // Each row loads the writeback data when addressed, clears on reset.
      always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
          regs_reg[gi] <= '0;
        end else if (rd_waddr == REG_ADDR_W'(gi)) begin
          regs_reg[gi] <= rd_wdata;
        end
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_rport
      logic [DATA_W-1:0] rdata;

      // x0 reads zero; a read of the register being written sees the new value.
      always_comb begin
        if (rs_raddr[gi] == ZERO_REG) begin
          rdata = '0;
        end else if (rs_raddr[gi] == rd_waddr) begin
          rdata = rd_wdata;
        end else begin
          rdata = regs_reg[rs_raddr[gi]];
        end
      end

      assign rs_rdata[gi] = rdata;
    end
  endgenerate

endmodule

// File: rtl/csr_gpr_regfile.sv
// Architectural state: 32x32 GPR file plus RV32 machine-mode CSR file.
// Optional feature macro: CSR_MCYCLE_EN enables the 64-bit {mcycleh,mcycle}
// counter; without it both halves read zero and ignore writes.
module csr_gpr_regfile #(
  parameter int DATA_W     = csr_gpr_regfile_pkg::DATA_W,
  parameter int REG_ADDR_W = csr_gpr_regfile_pkg::REG_ADDR_W,
  parameter int CSR_ADDR_W = csr_gpr_regfile_pkg::CSR_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  csr_gpr_regfile_if.slave bus
);
  import csr_gpr_regfile_pkg::*;

  // ---------------------------------------------------------------- GPRs
  logic [1:0][REG_ADDR_W-1:0] rs_raddr;
  logic [1:0][DATA_W-1:0]     rs_rdata;
  logic [DATA_W-1:0]          rd_wdata;

  // Load and execute paths are never active together, so OR merges them.
  assign rd_wdata = bus.extl_rd_wdata | bus.sb_rd_wdata;
  assign rs_raddr = {bus.rs2_raddr, bus.rs1_raddr};

  csr_gpr_regfile_gpr_bank #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_gpr_bank (
    .clk      (clk),
    .rst      (rst),
    .rd_waddr (bus.rd_waddr),
    .rd_wdata (rd_wdata),
    .rs_raddr (rs_raddr),
    .rs_rdata (rs_rdata)
  );

  assign bus.rs1_rdata_o = rs_rdata[0];
  assign bus.rs2_rdata_o = rs_rdata[1];

  // ---------------------------------------------------------------- CSRs
  logic [CSR_ADDR_W-1:0] csr_waddr;
  logic [CSR_ADDR_W-1:0] csr_raddr;
  csr_rw_t               csr_reg;
  csr_rw_t               csr_next;
  logic [DATA_W-1:0]     mcycle_rdata;
  logic [DATA_W-1:0]     mcycleh_rdata;
  logic [DATA_W-1:0]     csr_stored;

  assign csr_waddr = bus.csr_waddr;
  assign csr_raddr = bus.csr_raddr;

  // Decode the write address onto the plain RW registers; others are ignored.
  always_comb begin
    csr_next = csr_reg;
    case (csr_waddr)
      CSR_MSTATUS:  csr_next.mstatus  = bus.csr_wdata;
      CSR_MIE:      csr_next.mie      = bus.csr_wdata;
      CSR_MTVEC:    csr_next.mtvec    = bus.csr_wdata;
      CSR_MSCRATCH: csr_next.mscratch = bus.csr_wdata;
      CSR_MEPC:     csr_next.mepc     = bus.csr_wdata;
      CSR_MCAUSE:   csr_next.mcause   = bus.csr_wdata;
      CSR_MTVAL:    csr_next.mtval    = bus.csr_wdata;
      CSR_MIP:      csr_next.mip      = bus.csr_wdata;
      default:      csr_next = csr_reg;
    endcase
  end

  // RW CSR storage, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      csr_reg <= '0;
    end else begin
      csr_reg <= csr_next;
    end
  end

`ifdef CSR_MCYCLE_EN
  localparam int CYCLE_W = 2 * DATA_W;

  logic [DATA_W-1:0]  mcycle_reg;
  logic [DATA_W-1:0]  mcycleh_reg;
  logic [DATA_W-1:0]  mcycle_next;
  logic [DATA_W-1:0]  mcycleh_next;
  logic [CYCLE_W-1:0] cycle_inc;

  // 64-bit increment; a write replaces only the addressed half, so the
  // other half still sees the carry from the pre-write low word.
  always_comb begin
    cycle_inc    = {mcycleh_reg, mcycle_reg} + CYCLE_W'(1);
    mcycle_next  = cycle_inc[DATA_W-1:0];
    mcycleh_next = cycle_inc[CYCLE_W-1:DATA_W];
    if (csr_waddr == CSR_MCYCLE) begin
      mcycle_next = bus.csr_wdata;
    end
    if (csr_waddr == CSR_MCYCLEH) begin
      mcycleh_next = bus.csr_wdata;
    end
  end

  // Cycle counter state, counting from zero once reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      mcycle_reg  <= '0;
      mcycleh_reg <= '0;
    end else begin
      mcycle_reg  <= mcycle_next;
      mcycleh_reg <= mcycleh_next;
    end
  end

  assign mcycle_rdata  = mcycle_reg;
  assign mcycleh_rdata = mcycleh_reg;
`else
  assign mcycle_rdata  = '0;
  assign mcycleh_rdata = '0;
`endif

  // Stored-value read mux; read-only IDs and unmapped addresses return zero.
  always_comb begin
    csr_stored = '0;
    case (csr_raddr)
      CSR_MSTATUS:  csr_stored = csr_reg.mstatus;
      CSR_MISA:     csr_stored = MISA_VALUE;
      CSR_MIE:      csr_stored = csr_reg.mie;
      CSR_MTVEC:    csr_stored = csr_reg.mtvec;
      CSR_MSCRATCH: csr_stored = csr_reg.mscratch;
      CSR_MEPC:     csr_stored = csr_reg.mepc;
      CSR_MCAUSE:   csr_stored = csr_reg.mcause;
      CSR_MTVAL:    csr_stored = csr_reg.mtval;
      CSR_MIP:      csr_stored = csr_reg.mip;
      CSR_MCYCLE:   csr_stored = mcycle_rdata;
      CSR_MCYCLEH:  csr_stored = mcycleh_rdata;
      default:      csr_stored = '0;
    endcase
  end

  // Same-cycle bypass of an in-flight write, only for writable targets.
  always_comb begin
    if ((csr_raddr == csr_waddr) && csr_is_writable(csr_waddr)) begin
      bus.csr_rdata_o = bus.csr_wdata;
    end else begin
      bus.csr_rdata_o = csr_stored;
    end
  end

endmodule

// File: tb/tb_csr_gpr_regfile.sv
// Scoreboard bench for csr_gpr_regfile: a stimulus process drives one
// transaction per clock and queues the expected read data from a reference
// model; a monitor pops and compares on the falling edge.
module tb_csr_gpr_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  csr_gpr_regfile_if bus_if ();

  csr_gpr_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] csr;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  // Reference model state
  logic [31:0] gpr_m [32];
  logic [31:0] csr_m [int];
  logic [63:0] cyc_m;

  // Previously driven transaction, committed at the next rising edge
  logic        p_rst = 1'b0;
  int          p_cwa = 0;
  logic [31:0] p_cwd = '0;
  int          p_rwa = 0;
  logic [31:0] p_wd  = '0;

  function automatic bit is_rw(int a);
    bit r;
    r = a inside {'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344};
`ifdef CSR_MCYCLE_EN
    r = r || (a == 'hB00) || (a == 'hB80);
`endif
    return r;
  endfunction

  function automatic logic [31:0] csr_peek(int a);
    case (a)
      'h301: return 32'h4000_0100;
`ifdef CSR_MCYCLE_EN
      'hB00: return cyc_m[31:0];
      'hB80: return cyc_m[63:32];
`endif
      default: return (is_rw(a) && csr_m.exists(a)) ? csr_m[a] : 32'h0;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) gpr_m[i] = '0;
    csr_m.delete();
    cyc_m = '0;
  endfunction

  function automatic void check(string nm, string fld, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %08h required %08h", nm, fld, act, req);
  endfunction

  // One transaction per clock: commit last cycle's writes, drive new inputs,
  // queue the expected combinational read data.
  task automatic step(input logic r, input int cwa, input logic [31:0] cwd, input int cra,
                      input int rwa, input logic [31:0] ex, input logic [31:0] sb,
                      input int ra1, input int ra2, input string nm);
    exp_t        e;
    logic [63:0] nxt;
    logic [31:0] wd;
    @(posedge clk);
    if (p_rst) begin
      if (p_rwa != 0) gpr_m[p_rwa] = p_wd;
      if (is_rw(p_cwa)) csr_m[p_cwa] = p_cwd;
`ifdef CSR_MCYCLE_EN
      nxt = cyc_m + 64'd1;
      if (p_cwa == 'hB00) nxt[31:0]  = p_cwd;
      if (p_cwa == 'hB80) nxt[63:32] = p_cwd;
      cyc_m = nxt;
`else
      nxt = '0;
`endif
    end
    #1;
    rst                  = r;
    bus_if.csr_waddr     = 12'(cwa);
    bus_if.csr_wdata     = cwd;
    bus_if.csr_raddr     = 12'(cra);
    bus_if.rd_waddr      = 5'(rwa);
    bus_if.extl_rd_wdata = ex;
    bus_if.sb_rd_wdata   = sb;
    bus_if.rs1_raddr     = 5'(ra1);
    bus_if.rs2_raddr     = 5'(ra2);
    wd = ex | sb;
    p_rst = r; p_cwa = cwa; p_cwd = cwd; p_rwa = rwa; p_wd = wd;
    if (!r) model_clear();
    e.rs1 = (ra1 == 0) ? 32'h0 : ((ra1 == rwa) ? wd : gpr_m[ra1]);
    e.rs2 = (ra2 == 0) ? 32'h0 : ((ra2 == rwa) ? wd : gpr_m[ra2]);
    e.csr = ((cra == cwa) && is_rw(cwa)) ? cwd : csr_peek(cra);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_txn++;
        $display("txn %0d %s rs1=%08h rs2=%08h csr=%08h", n_txn, nm,
                 bus_if.rs1_rdata_o, bus_if.rs2_rdata_o, bus_if.csr_rdata_o);
        check(nm, "rs1", bus_if.rs1_rdata_o, e.rs1);
        check(nm, "rs2", bus_if.rs2_rdata_o, e.rs2);
        check(nm, "csr", bus_if.csr_rdata_o, e.csr);
      end
    end
  end

  task automatic random_steps(input int n);
    int          addrs [17];
    int          cwa, cra, rwa, ra1, ra2;
    logic [31:0] d, ex, sb;
    addrs = '{'h000, 'h300, 'h301, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343,
              'h344, 'hB00, 'hB80, 'hF11, 'hF12, 'hF13, 'hF14, 'h7C0};
    for (int i = 0; i < n; i++) begin
      cwa = ($urandom_range(0, 3) == 0) ? 0 : addrs[$urandom_range(0, 16)];
      cra = ($urandom_range(0, 1) == 0) ? cwa : addrs[$urandom_range(0, 16)];
      rwa = $urandom_range(0, 31);
      d   = $urandom;
      if ($urandom_range(0, 1) == 0) begin ex = d; sb = '0; end
      else begin ex = '0; sb = d; end
      ra1 = ($urandom_range(0, 2) == 0) ? rwa : $urandom_range(0, 31);
      ra2 = ($urandom_range(0, 2) == 0) ? rwa : $urandom_range(0, 31);
      step(1'b1, cwa, $urandom, cra, rwa, ex, sb, ra1, ra2, "random");
    end
  endtask

  initial begin
    model_clear();
    bus_if.csr_waddr = '0; bus_if.csr_wdata = '0; bus_if.csr_raddr = '0;
    bus_if.rd_waddr = '0; bus_if.extl_rd_wdata = '0; bus_if.sb_rd_wdata = '0;
    bus_if.rs1_raddr = '0; bus_if.rs2_raddr = '0;

    // Reset state
    step(0, 0, 0, 'h341, 0, 0, 0, 5, 31, "reset");
    step(0, 0, 0, 'h341, 0, 0, 0, 1, 2, "reset_hold");
    // GPR writes, x0 protection, port bypass
    step(1, 0, 0, 'h341, 0, 32'hFFFF, 32'hFFFF_0000, 0, 0, "x0_write");
    step(1, 0, 0, 'h341, 1, 32'h8, 0, 0, 1, "x1_write");
    step(1, 0, 0, 'h341, 2, 0, 32'h2, 1, 2, "x2_write");
    step(1, 0, 0, 'h341, 0, 0, 0, 1, 2, "x1x2_read");
    step(1, 0, 0, 'h341, 4, 32'h4, 0, 4, 0, "gpr_bypass");
    step(1, 0, 0, 'h341, 0, 0, 0, 4, 0, "gpr_after");
    // CSR writes, ignored writes, read-only values
    step(1, 'h341, 32'hC3, 'h300, 0, 0, 0, 0, 0, "mepc_write");
    step(1, 0, 0, 'h341, 0, 0, 0, 0, 0, "mepc_read");
    step(1, 0, 32'hDEAD_BEEF, 'h000, 0, 0, 0, 0, 0, "mdisable_write");
    step(1, 0, 0, 'h341, 0, 0, 0, 0, 0, "mepc_kept");
    step(1, 0, 0, 'hF11, 0, 0, 0, 0, 0, "mvendorid");
    step(1, 'h301, 32'h0, 'h301, 0, 0, 0, 0, 0, "misa_ro");
    step(1, 0, 0, 'h301, 0, 0, 0, 0, 0, "misa");
    step(1, 'hF14, 32'h55, 'hF14, 0, 0, 0, 0, 0, "mhartid_ro");
    // CSR bypass
    step(1, 'h300, 32'hAA, 'h300, 0, 0, 0, 0, 0, "mstatus_bypass");
    step(1, 0, 0, 'h300, 0, 0, 0, 0, 0, "mstatus_after");
    // Cycle counter (reads zero when the counter is not built)
    step(1, 0, 0, 'hB00, 0, 0, 0, 0, 0, "mcycle_a");
    step(1, 0, 0, 'hB00, 0, 0, 0, 0, 0, "mcycle_b");
    step(1, 'hB00, 32'hFFFF_FFFF, 'hB80, 0, 0, 0, 0, 0, "mcycle_wr");
    step(1, 0, 0, 'hB00, 0, 0, 0, 0, 0, "mcycle_wrap");
    step(1, 0, 0, 'hB80, 0, 0, 0, 0, 0, "mcycleh_carry");
    step(1, 'hB80, 32'h1234, 'hB00, 0, 0, 0, 0, 0, "mcycleh_wr");
    step(1, 0, 0, 'hB80, 0, 0, 0, 0, 0, "mcycleh_read");

    random_steps(300);

    // Asynchronous reset mid-run: state must clear before the next edge
    step(0, 0, 0, 'h341, 0, 0, 0, 1, 2, "async_reset");
    step(0, 0, 0, 'h300, 0, 0, 0, 3, 4, "reset_hold2");
    step(1, 0, 0, 'hB00, 0, 0, 0, 1, 2, "reset_release");
    random_steps(40);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
